// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters
// (core and debug port) and the single-ported data memory.
interface dmem_arbiter_if;
    // Core requester
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_ready;
    logic [31:0] core_rdata;
    logic        core_stall;
    // Debug requester
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic [31:0] dbg_rdata;
    // Memory side (synchronous write, combinational read)
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    // Status
    logic        stall_clr;
    logic [15:0] stall_cycles;
    logic [1:0]  owner;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_ready, core_rdata, core_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        input  stall_clr,
        output stall_cycles, owner
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_ready, core_rdata, core_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        output stall_clr,
        input  stall_cycles, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (core / debug) arbiter in front of a single-ported data
// memory. One access per granted cycle; a requester that just completed is
// not eligible at that edge, so contention alternates and a lone requester
// gets every other cycle. Also counts core stall cycles (saturating).
module dmem_arbiter (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CORE = 2'b01,
        DBG  = 2'b10
    } arbState_t;

    localparam logic LAST_CORE = 1'b0;
    localparam logic LAST_DBG  = 1'b1;

    arbState_t   stateReg, stateNext;
    logic        lastOwnerReg, lastOwnerNext;
    logic [15:0] stallCyclesReg, stallCyclesNext;

    logic        coreReady, dbgReady;
    logic        coreEligible, dbgEligible;
    logic        memWe;
    logic [31:0] memAddr, memWdata;

    // State, arbitration history and stall counter; reset starts with debug
    // as last owner so the core wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg       <= IDLE;
            lastOwnerReg   <= LAST_DBG;
            stallCyclesReg <= '0;
        end else begin
            stateReg       <= stateNext;
            lastOwnerReg   <= lastOwnerNext;
            stallCyclesReg <= stallCyclesNext;
        end
    end

    // Grant decode, memory steering, next-state selection and counter update.
    always_comb begin
        coreReady = (stateReg == CORE) && bus.core_req;
        dbgReady  = (stateReg == DBG)  && bus.dbg_req;

        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        case (stateReg)
            CORE: begin
                memWe    = bus.core_we && bus.core_req;
                memAddr  = bus.core_addr;
                memWdata = bus.core_wdata;
            end
            DBG: begin
                memWe    = bus.dbg_we && bus.dbg_req;
                memAddr  = bus.dbg_addr;
                memWdata = bus.dbg_wdata;
            end
            default: ;
        endcase

        // A requester whose transfer completes this cycle sits out one edge;
        // for the core this is exactly the stall condition.
        coreEligible = bus.core_req && !coreReady;
        dbgEligible  = bus.dbg_req  && !dbgReady;

        if (coreEligible && dbgEligible)
            stateNext = (lastOwnerReg == LAST_CORE) ? DBG : CORE;
        else if (coreEligible)
            stateNext = CORE;
        else if (dbgEligible)
            stateNext = DBG;
        else
            stateNext = IDLE;

        lastOwnerNext = lastOwnerReg;
        if (stateReg == CORE)
            lastOwnerNext = LAST_CORE;
        else if (stateReg == DBG)
            lastOwnerNext = LAST_DBG;

        // Clear wins over a simultaneous increment; count sticks at all-ones.
        stallCyclesNext = stallCyclesReg;
        if (bus.stall_clr)
            stallCyclesNext = '0;
        else if (coreEligible && (stallCyclesReg != 16'hFFFF))
            stallCyclesNext = stallCyclesReg + 16'd1;
    end

    assign bus.core_ready   = coreReady;
    assign bus.core_rdata   = coreReady ? bus.mem_rdata : '0;
    assign bus.core_stall   = coreEligible;
    assign bus.dbg_ready    = dbgReady;
    assign bus.dbg_rdata    = dbgReady ? bus.mem_rdata : '0;
    assign bus.mem_we       = memWe;
    assign bus.mem_addr     = memAddr;
    assign bus.mem_wdata    = memWdata;
    assign bus.stall_cycles = stallCyclesReg;
    assign bus.owner        = stateReg;
endmodule
